fifo_drain: RTL and testbench

//  Downstream consumer of the FIFO control/memory pair: issues single-cycle remove requests while
//  the FIFO is non-empty, captures the memory read word after a fixed latency, and presents it on
//  a valid/ready stream. Credit-limited so it never requests more words than it can buffer.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/drain_buf.sv | 71 +++++++
 rtl/fifo_drain_chk.sv | 33 +++
 rtl/fifo_drain.sv | 126 ++++++++++++
 tb/tb_fifo_drain.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: data width, drain timing defaults, drain FSM states,
// and a modulo index helper used by the circular buffer.
package fifo_pkg;

    localparam int FIFO_WIDTH   = 8;
    localparam int READ_LAT_DEF = 2;
    localparam int REQ_GAP_DEF  = 3;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_GAP  = 1'b1
    } drain_state_t;

    // Advance a buffer index, wrapping at depth (depth need not be a power of two)
    function automatic int wrap_inc(input int idx, input int depth);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= depth) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/drain_buf.sv
// Circular DEPTH x WIDTH register buffer with push, pop, clear and fill count.
// Push and pop on the same edge keep the count and preserve order.
module drain_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                       ck,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [OW-1:0]    occ_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests: pop only when non-empty, push only with room or a simultaneous pop
    always_comb begin
        pop_s = pop && (occ_r != {OW{1'b0}});
        if (clr) begin
            push_s = 1'b0;
        end else begin
            push_s = push && ((occ_r < OW'(DEPTH)) || pop_s);
        end
    end

    // Storage, pointers and fill count; clear drops contents and any same-edge capture
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= PW'(wrap_inc(int'(wr_ptr_r), DEPTH));
            end
            if (pop_s) begin
                rd_ptr_r <= PW'(wrap_inc(int'(rd_ptr_r), DEPTH));
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign occupancy = occ_r;

endmodule

// File: rtl/fifo_drain_chk.sv
// Protocol checker for fifo_drain, connected to its ports.
module fifo_drain_chk #(
    parameter int WIDTH     = 8,
    parameter int REQ_GAP   = 3,
    parameter int BUF_DEPTH = 2
) (
    input logic                           ck,
    input logic                           reset_n,
    input logic                           flush,
    input logic                           fifo_remove,
    input logic                           m_valid,
    input logic                           m_ready,
    input logic [WIDTH-1:0]               m_data,
    input logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    a_no_overflow: assert property (@(posedge ck) disable iff (!reset_n)
        occupancy <= OW'(BUF_DEPTH));

    a_valid_occ: assert property (@(posedge ck) disable iff (!reset_n)
        m_valid == (occupancy != {OW{1'b0}}));

    a_hold: assert property (@(posedge ck) disable iff (!reset_n)
        (m_valid && !m_ready && !flush) |=> $stable(m_data));

    if (REQ_GAP > 1) begin : g_gap
        a_spacing: assert property (@(posedge ck) disable iff (!reset_n)
            fifo_remove |=> !fifo_remove);
    end

endmodule

// File: rtl/fifo_drain.sv
// FIFO drain: issues spaced remove pulses while the FIFO has data and the output
// buffer has credit, captures read data after READ_LAT edges and presents it on a
// valid/ready stream.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int READ_LAT  = READ_LAT_DEF,
    parameter int REQ_GAP   = REQ_GAP_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           ck,
    input  logic                           reset_n,
    input  logic                           fifo_empty,
    input  logic                           fifo_insert,
    input  logic [WIDTH-1:0]               fifo_rdata,
    input  logic                           flush,
    output logic                           fifo_remove,
    output logic [WIDTH-1:0]               m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int CW = $clog2(READ_LAT + BUF_DEPTH + 1);
    localparam int GW = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;

    drain_state_t        state_r;
    drain_state_t        state_next_s;
    logic [GW-1:0]       gap_r;
    logic [GW-1:0]       gap_next_s;
    logic [READ_LAT-1:0] pipe_r;
    logic [READ_LAT:0]   pipe_shift_s;
    logic [CW-1:0]       inflight_s;
    logic                credit_ok_s;
    logic                remove_s;
    logic                capture_s;
    logic                pop_s;
    logic [OW-1:0]       occ_s;

    // Count outstanding reads and check that one more still fits in the buffer
    always_comb begin
        inflight_s = {CW{1'b0}};
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_s = inflight_s + CW'(pipe_r[i]);
        end
        credit_ok_s = (CW'(occ_s) + inflight_s) < CW'(BUF_DEPTH);
    end

    // Drain FSM next state and remove pulse; the writer wins over a remove in the same cycle
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_r;
        remove_s     = 1'b0;
        case (state_r)
            D_IDLE: begin
                remove_s = reset_n && !fifo_empty && !fifo_insert && !flush && credit_ok_s;
                if (remove_s && (REQ_GAP > 1)) begin
                    state_next_s = D_GAP;
                    gap_next_s   = GW'(REQ_GAP - 1);
                end else begin
                    state_next_s = D_IDLE;
                end
            end
            D_GAP: begin
                gap_next_s = gap_r - GW'(1);
                if (gap_r == GW'(1)) begin
                    state_next_s = D_IDLE;
                end else begin
                    state_next_s = D_GAP;
                end
            end
            default: begin
                state_next_s = D_IDLE;
                gap_next_s   = {GW{1'b0}};
            end
        endcase
    end

    // FSM state and gap counter; flush does not shorten a running gap
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= D_IDLE;
            gap_r   <= {GW{1'b0}};
        end else begin
            state_r <= state_next_s;
            gap_r   <= gap_next_s;
        end
    end

    assign pipe_shift_s = {pipe_r, remove_s};

    // In-flight read tags; flush discards reads whose data has not arrived yet
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            pipe_r <= {READ_LAT{1'b0}};
        end else if (flush) begin
            pipe_r <= {READ_LAT{1'b0}};
        end else begin
            pipe_r <= pipe_shift_s[READ_LAT-1:0];
        end
    end

    assign capture_s = pipe_r[READ_LAT-1];
    assign pop_s     = m_valid && m_ready;

    drain_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .ck        (ck),
        .reset_n   (reset_n),
        .clr       (flush),
        .push      (capture_s),
        .push_data (fifo_rdata),
        .pop       (pop_s),
        .head_data (m_data),
        .occupancy (occ_s)
    );

    assign occupancy   = occ_s;
    assign m_valid     = (occ_s != {OW{1'b0}});
    assign fifo_remove = remove_s;

endmodule

// File: tb/tb_fifo_drain.sv
`timescale 1ns/1ps
module tb_fifo_drain;

    localparam int WIDTH     = 8;
    localparam int READ_LAT  = 2;
    localparam int REQ_GAP   = 3;
    localparam int BUF_DEPTH = 2;
    localparam int OW        = $clog2(BUF_DEPTH + 1);

    logic             ck          = 1'b0;
    logic             reset_n     = 1'b0;
    logic             fifo_empty  = 1'b1;
    logic             fifo_insert = 1'b0;
    logic [WIDTH-1:0] fifo_rdata  = 8'h00;
    logic             flush       = 1'b0;
    logic             m_ready     = 1'b0;
    logic             fifo_remove;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [OW-1:0]    occupancy;
    logic [WIDTH-1:0] ins_data    = 8'h00;

    always #5 ck = ~ck;

    fifo_drain #(
        .WIDTH(WIDTH), .READ_LAT(READ_LAT), .REQ_GAP(REQ_GAP), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .ck(ck), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_insert(fifo_insert),
        .fifo_rdata(fifo_rdata), .flush(flush), .fifo_remove(fifo_remove),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .occupancy(occupancy)
    );

    fifo_drain_chk #(
        .WIDTH(WIDTH), .REQ_GAP(REQ_GAP), .BUF_DEPTH(BUF_DEPTH)
    ) u_chk (
        .ck(ck), .reset_n(reset_n), .flush(flush), .fifo_remove(fifo_remove),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy)
    );

    typedef struct packed {
        logic          m_ready;
        logic          exp_rem;
        logic          exp_valid;
        logic [OW-1:0] exp_occ;
    } vec_t;

    vec_t             vecs [7];
    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] exp_q  [$];
    logic [WIDTH-1:0] rd_stage = 8'h00;
    int               n_pass = 0;
    int               n_total = 0;
    int               n_acc = 0;
    int               n_rem = 0;
    logic             s_rem;
    logic             s_valid;
    logic [OW-1:0]    s_occ;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // One clock: sample pre-edge outputs, score accepted words, advance FIFO/memory model
    task automatic tick();
        logic [WIDTH-1:0] w;
        logic             s_ins;
        logic             s_fl;
        w = 8'h00;
        #1;
        s_rem   = fifo_remove;
        s_valid = m_valid;
        s_occ   = occupancy;
        s_ins   = fifo_insert;
        s_fl    = flush;
        if (m_valid && m_ready && reset_n) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_extra: got word %0h required none", m_data);
            end else begin
                check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        if (s_rem) begin
            n_rem++;
        end
        @(posedge ck);
        #1;
        fifo_rdata = rd_stage;
        if (!reset_n || s_fl) begin
            exp_q.delete();
        end
        if (s_fl) begin
            fifo_q.delete();
        end
        if (s_rem) begin
            if (fifo_q.size() == 0) begin
                n_total++;
                $display("FAIL remove_on_empty: got remove=1 required 0");
            end else begin
                w = fifo_q.pop_front();
                exp_q.push_back(w);
            end
            rd_stage = w;
        end
        if (s_ins) begin
            fifo_q.push_back(ins_data);
        end
        fifo_empty = (fifo_q.size() == 0);
        @(negedge ck);
    endtask

    task automatic wait_remove(input string name);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_rem) break;
        end
        check(name, 32'(s_rem), 32'd1);
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    initial begin
        int acc0;
        int rem0;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd1};

        // Reset with a non-empty FIFO
        @(negedge ck);
        load(8'hA5);
        load(8'h11);
        m_ready = 1'b1;
        repeat (3) tick();
        check("rst_remove", 32'(fifo_remove), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        reset_n = 1'b1;

        // 1: latency and request spacing, cycle by cycle
        for (int i = 0; i < 7; i++) begin
            m_ready = vecs[i].m_ready;
            tick();
            check($sformatf("t1_rem_c%0d", i), 32'(s_rem), 32'(vecs[i].exp_rem));
            check($sformatf("t1_valid_c%0d", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("t1_occ_c%0d", i), 32'(s_occ), 32'(vecs[i].exp_occ));
        end
        tick();
        check("t1_accepted", 32'(n_acc), 32'd2);

        // 3: empty FIFO never requests
        rem0 = n_rem;
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_valid || (s_occ != 2'd0)) acc0++;
        end
        check("t3_removes", 32'(n_rem - rem0), 32'd0);
        check("t3_valid_occ", 32'(acc0), 32'd0);

        // 2: back-pressure limits requests to the buffer depth
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'h10 + i));
        rem0 = n_rem;
        acc0 = n_acc;
        repeat (15) tick();
        check("t2_removes", 32'(n_rem - rem0), 32'd2);
        check("t2_occ", 32'(occupancy), 32'd2);
        check("t2_valid", 32'(m_valid), 32'd1);
        check("t2_head", 32'(m_data), 32'h10);
        check("t2_last_rem", 32'(s_rem), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 40 && (n_acc - acc0) < 5; k++) tick();
        repeat (2) tick();
        check("t2_drained", 32'(n_acc - acc0), 32'd5);
        check("t2_total_rem", 32'(n_rem - rem0), 32'd5);
        check("t2_occ_end", 32'(occupancy), 32'd0);

        // 4: insert has priority over remove
        repeat (4) tick();
        rem0 = n_rem;
        acc0 = n_acc;
        load(8'h5A);
        fifo_insert = 1'b1;
        ins_data    = 8'h3C;
        tick();
        check("t4_blocked", 32'(s_rem), 32'd0);
        fifo_insert = 1'b0;
        tick();
        check("t4_fires", 32'(s_rem), 32'd1);
        repeat (15) tick();
        check("t4_accepted", 32'(n_acc - acc0), 32'd2);
        check("t4_removes", 32'(n_rem - rem0), 32'd2);
        check("t4_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // 5: flush one cycle after a remove with one word buffered
        m_ready = 1'b0;
        repeat (4) tick();
        load(8'hB1);
        load(8'hB2);
        load(8'hB3);
        wait_remove("t5_rem1");
        wait_remove("t5_rem2");
        check("t5_occ_pre", 32'(occupancy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_occ_post", 32'(occupancy), 32'd0);
        check("t5_valid_post", 32'(m_valid), 32'd0);
        load(8'hB4);
        tick();
        check("t5_gap_held", 32'(s_rem), 32'd0);
        tick();
        check("t5_resume", 32'(s_rem), 32'd1);
        m_ready = 1'b1;
        acc0 = n_acc;
        repeat (10) tick();
        check("t5_accepted", 32'(n_acc - acc0), 32'd1);

        // 6: asynchronous reset while a read is in flight and a word is presented
        m_ready = 1'b0;
        repeat (4) tick();
        load(8'hC1);
        load(8'hC2);
        wait_remove("t6_rem1");
        wait_remove("t6_rem2");
        tick();
        check("t6_valid_pre", 32'(m_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(m_valid), 32'd0);
        check("t6_async_occ", 32'(occupancy), 32'd0);
        check("t6_async_data", 32'(m_data), 32'd0);
        check("t6_async_remove", 32'(fifo_remove), 32'd0);
        exp_q.delete();
        @(negedge ck);
        repeat (2) tick();
        reset_n = 1'b1;
        m_ready = 1'b1;
        acc0 = n_acc;
        repeat (8) tick();
        check("t6_no_stale", 32'(n_acc - acc0), 32'd0);
        check("t6_valid_idle", 32'(m_valid), 32'd0);
        load(8'hD7);
        repeat (10) tick();
        check("t6_resume", 32'(n_acc - acc0), 32'd1);
        check("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
